// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM receive path.
package tdm_pkg;

    // Framing state: searching for frame_sync, or tracking slots.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Slot index; also the value presented on the upstream select lines.
    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;

    localparam int ERR_CNT_MAX = 255;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'(ERR_CNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Two-bit slot counter that drives the upstream S1:S0 selects.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,    // back to slot A (frame end, error, hunt)
    input  logic  load1,  // slot A just captured, expect slot B next
    input  logic  inc,    // advance to the following slot
    output slot_t sel
);

    // Slot register; clear wins over load, load wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= SLOT_A;
        end else if (clr) begin
            sel <= SLOT_A;
        end else if (load1) begin
            sel <= SLOT_B;
        end else if (inc) begin
            sel <= sel + 2'd1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: tracks frame slots, stages partial
// frames and publishes complete frames with a one-cycle strobe.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W            = 1,
    parameter bit REQUIRE_SYNC = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] line_in,
    input  logic         line_valid,
    input  logic         frame_sync,
    output logic [1:0]   sel,
    output logic [W-1:0] ch_a,
    output logic [W-1:0] ch_b,
    output logic [W-1:0] ch_c,
    output logic [W-1:0] ch_d,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err,
    output logic [7:0]   err_cnt
);

    state_t       state, state_nxt;
    slot_t        slot;
    logic         slot_clr, slot_load1, slot_inc;
    logic         store_a, store_b, store_c;
    logic         frame_done, err;
    logic [W-1:0] stage_a, stage_b, stage_c;

    tdm_slot_ctr u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (slot_clr),
        .load1 (slot_load1),
        .inc   (slot_inc),
        .sel   (slot)
    );

    assign sel    = slot;
    assign locked = (state == LOCKED);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat classification: decides capture, slot movement and errors.
    always_comb begin
        state_nxt  = state;
        slot_clr   = 1'b0;
        slot_load1 = 1'b0;
        slot_inc   = 1'b0;
        store_a    = 1'b0;
        store_b    = 1'b0;
        store_c    = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        if (line_valid) begin
            unique case (state)
                HUNT: begin
                    // Unsynced beats are dropped; slot is already A here.
                    if (frame_sync) begin
                        store_a    = 1'b1;
                        slot_load1 = 1'b1;
                        state_nxt  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot == SLOT_A) begin
                        // A sync on slot A is the normal case, not a resync.
                        if (frame_sync || !REQUIRE_SYNC) begin
                            store_a    = 1'b1;
                            slot_load1 = 1'b1;
                        end else begin
                            err       = 1'b1;
                            slot_clr  = 1'b1;
                            state_nxt = HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early sync: abandon the partial frame, restart at A.
                        err        = 1'b1;
                        store_a    = 1'b1;
                        slot_load1 = 1'b1;
                    end else begin
                        unique case (slot)
                            SLOT_B: begin
                                store_b  = 1'b1;
                                slot_inc = 1'b1;
                            end
                            SLOT_C: begin
                                store_c  = 1'b1;
                                slot_inc = 1'b1;
                            end
                            default: begin
                                frame_done = 1'b1;
                                slot_clr   = 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_clr  = 1'b1;
                end
            endcase
        end
    end

    // Staging for channels A..C while the rest of the frame arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_a <= '0;
            stage_b <= '0;
            stage_c <= '0;
        end else begin
            if (store_a) stage_a <= line_in;
            if (store_b) stage_b <= line_in;
            if (store_c) stage_c <= line_in;
        end
    end

    // Publish the whole frame on the slot-D edge; D comes straight off the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_a        <= '0;
            ch_b        <= '0;
            ch_c        <= '0;
            ch_d        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                ch_a <= stage_a;
                ch_b <= stage_b;
                ch_c <= stage_c;
                ch_d <= line_in;
            end
        end
    end

    // Error pulse and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            sync_err <= err;
            if (err) err_cnt <= sat_inc8(err_cnt);
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: two instances (REQUIRE_SYNC=1 and 0) fed the same
// beats, checked every cycle against a frame-level model plus literals.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] line_in = 4'd0;
    logic       line_valid = 1'b0;
    logic       frame_sync = 1'b0;
    bit         run = 1'b0;

    logic [1:0] sel [2];
    logic [3:0] ch_a [2];
    logic [3:0] ch_b [2];
    logic [3:0] ch_c [2];
    logic [3:0] ch_d [2];
    logic       frame_valid [2];
    logic       locked [2];
    logic       sync_err [2];
    logic [7:0] err_cnt [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0 insists on sync every frame; instance 1 accepts by count.
    tdm_demux4 #(.W(4), .REQUIRE_SYNC(1'b1)) u_rs1 (
        .clk(clk), .rst_n(rst_n), .line_in(line_in), .line_valid(line_valid),
        .frame_sync(frame_sync), .sel(sel[0]), .ch_a(ch_a[0]), .ch_b(ch_b[0]),
        .ch_c(ch_c[0]), .ch_d(ch_d[0]), .frame_valid(frame_valid[0]),
        .locked(locked[0]), .sync_err(sync_err[0]), .err_cnt(err_cnt[0])
    );

    tdm_demux4 #(.W(4), .REQUIRE_SYNC(1'b0)) u_rs0 (
        .clk(clk), .rst_n(rst_n), .line_in(line_in), .line_valid(line_valid),
        .frame_sync(frame_sync), .sel(sel[1]), .ch_a(ch_a[1]), .ch_b(ch_b[1]),
        .ch_c(ch_c[1]), .ch_d(ch_d[1]), .frame_valid(frame_valid[1]),
        .locked(locked[1]), .sync_err(sync_err[1]), .err_cnt(err_cnt[1])
    );

    // Frame model: words collected so far in the current frame, last frame.
    bit         m_lock [2];
    int         m_n [2];
    logic [3:0] m_w [2][4];
    logic [3:0] m_ch [2][4];
    bit         m_fv [2];
    bit         m_err [2];
    int         m_cnt [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_lock[i] = 0; m_n[i] = 0; m_fv[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
            for (int k = 0; k < 4; k++) begin
                m_w[i][k] = 4'd0; m_ch[i][k] = 4'd0;
            end
        end
    end

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_lock[i] = 0; m_n[i] = 0; m_fv[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
                for (int k = 0; k < 4; k++) begin
                    m_w[i][k] = 4'd0; m_ch[i][k] = 4'd0;
                end
            end else begin
                m_fv[i] = 0;
                m_err[i] = 0;
                if (line_valid) begin
                    if (!m_lock[i]) begin
                        if (frame_sync) begin
                            m_lock[i] = 1; m_w[i][0] = line_in; m_n[i] = 1;
                        end
                    end else if (m_n[i] == 0) begin
                        if (frame_sync || i == 1) begin
                            m_w[i][0] = line_in; m_n[i] = 1;
                        end else begin
                            m_err[i] = 1; m_lock[i] = 0;
                        end
                    end else if (frame_sync) begin
                        m_err[i] = 1; m_w[i][0] = line_in; m_n[i] = 1;
                    end else begin
                        m_w[i][m_n[i]] = line_in;
                        m_n[i]++;
                        if (m_n[i] == 4) begin
                            for (int k = 0; k < 4; k++) m_ch[i][k] = m_w[i][k];
                            m_fv[i] = 1;
                            m_n[i] = 0;
                        end
                    end
                    if (m_err[i] && m_cnt[i] < 255) m_cnt[i]++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "model_rs1" : "model_rs0",
                    {sel[i], locked[i], ch_a[i], ch_b[i], ch_c[i], ch_d[i],
                     frame_valid[i], sync_err[i], err_cnt[i]},
                    {(m_lock[i] ? 2'(m_n[i]) : 2'd0), m_lock[i], m_ch[i][0], m_ch[i][1],
                     m_ch[i][2], m_ch[i][3], m_fv[i], m_err[i], 8'(m_cnt[i])});
            end
        end
    end

    // One beat consumed on the next rising edge; returns 1 time unit after it.
    task automatic beat(input logic [3:0] d, input logic s);
        line_in = d;
        frame_sync = s;
        line_valid = 1'b1;
        @(posedge clk);
        #1;
        line_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_ch(input string nm, input int i, input logic [15:0] exp);
        chk(nm, {ch_a[i], ch_b[i], ch_c[i], ch_d[i]}, exp);
    endtask

    int gaps [4] = '{0, 3, 5, 1};

    initial begin
        #2 rst_n = 1'b0;
        #1 run = 1'b1;
        idle(2);
        chk("reset_outs", {sel[0], locked[0], frame_valid[0], sync_err[0], err_cnt[0]}, 64'd0);
        chk_ch("reset_ch", 0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsynced beats are discarded.
        beat(4'h9, 1'b0);
        beat(4'hA, 1'b0);
        chk("presync_sel_lock", {sel[0], locked[0], sel[1], locked[1]}, 64'd0);
        chk_ch("presync_ch", 0, 16'h0000);

        // First frame.
        beat(4'h1, 1'b1);
        chk("lock_rise", {locked[0], sel[0]}, {1'b1, 2'd1});
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        chk_ch("frame1_ch", 0, 16'h1234);
        chk("frame1_fv_sel_lock", {frame_valid[0], sel[0], locked[0]}, {1'b1, 2'd0, 1'b1});
        chk("model_pin_frame1", {m_ch[0][0], m_ch[0][1], m_ch[0][2], m_ch[0][3]}, 64'h1234);
        idle(1);
        chk("fv_one_cycle", frame_valid[0], 1'b0);

        // Resync at slot 2.
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        beat(4'h4, 1'b1);
        chk("resync_err", {sync_err[0], err_cnt[0], sync_err[1], err_cnt[1]},
            {1'b1, 8'd1, 1'b1, 8'd1});
        chk_ch("resync_keep", 0, 16'h1234);
        chk("resync_sel", sel[0], 2'd1);
        beat(4'h5, 1'b0);
        beat(4'h6, 1'b0);
        beat(4'h7, 1'b0);
        chk_ch("resync_frame", 0, 16'h4567);
        chk_ch("resync_frame_rs0", 1, 16'h4567);

        // Slot-0 beat without sync.
        beat(4'h8, 1'b0);
        chk("rs1_err_unlock", {sync_err[0], locked[0], sel[0], err_cnt[0]},
            {1'b1, 1'b0, 2'd0, 8'd2});
        chk("rs0_accept", {sync_err[1], locked[1], sel[1]}, {1'b0, 1'b1, 2'd1});
        beat(4'h9, 1'b0);
        beat(4'hA, 1'b0);
        beat(4'hB, 1'b0);
        chk_ch("rs0_frame", 1, 16'h89AB);
        chk("rs0_fv", frame_valid[1], 1'b1);
        chk_ch("rs1_hold", 0, 16'h4567);
        chk("rs1_hunt", {locked[0], frame_valid[0]}, 64'd0);

        // Idle gaps between beats.
        for (int k = 0; k < 4; k++) begin
            beat(4'hC + 4'(k), k == 0);
            idle(gaps[k]);
        end
        chk_ch("gap_frame_rs1", 0, 16'hCDEF);
        chk_ch("gap_frame_rs0", 1, 16'hCDEF);

        // Error counter saturation: repeated sync beats at slot 1.
        beat(4'h3, 1'b1);
        for (int k = 0; k < 300; k++) beat(4'(k), 1'b1);
        chk("err_sat", {err_cnt[0], err_cnt[1]}, {8'd255, 8'd255});
        chk("err_sat_locked", locked[0], 1'b1);

        // Asynchronous reset mid-frame.
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_outs",
            {sel[0], locked[0], frame_valid[0], sync_err[0], err_cnt[0], err_cnt[1]}, 64'd0);
        chk_ch("async_rst_ch", 0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beat(4'h6, 1'b0);
        chk("post_rst_hunt", {locked[0], sel[0]}, 64'd0);
        beat(4'hD, 1'b1);
        beat(4'hE, 1'b0);
        beat(4'hA, 1'b0);
        beat(4'hD, 1'b0);
        chk_ch("post_rst_frame", 0, 16'hDEAD);
        idle(2);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
